// File: rtl/ins_dec_pkg.sv
// Shared RV32I decode constants, format codes and the decoded-field payload.
package ins_dec_pkg;

  localparam int unsigned INS_W = 32;
  localparam int unsigned OPC_W = 7;
  localparam int unsigned REG_W = 5;

  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  // Decoded fields of one instruction (PC and immediate carried separately, XLEN wide).
  typedef struct packed {
    logic [OPC_W-1:0] op;
    logic [2:0]       funct3;
    logic [6:0]       funct7;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    fmt_e             fmt;
    logic             illegal;
  } dec_fields_t;

endpackage

// File: rtl/ins_dec_comb.sv
// Combinational RV32I decode of a single instruction word.
module ins_dec_comb
  import ins_dec_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INS_W-1:0] ins_i,
  output dec_fields_t      fld_o,
  output logic [XLEN-1:0]  imm_o
);

  logic [OPC_W-1:0] op;
  logic [2:0]       f3;
  logic [6:0]       f7;
  logic             legal;
  dec_fields_t      fld;
  logic [XLEN-1:0]  imm;

  assign op = ins_i[6:0];
  assign f3 = ins_i[14:12];
  assign f7 = ins_i[31:25];

  // Select format, fields and immediate by opcode; illegal encodings collapse to FMT_ILL.
  always_comb begin
    fld         = '0;
    fld.op      = op;
    fld.fmt     = FMT_ILL;
    fld.illegal = 1'b0;
    imm         = '0;
    legal       = 1'b0;
    case (op)
      OPC_OP: begin
        legal      = (f7 == F7_ZERO) || ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
        fld.fmt    = FMT_R;
        fld.funct7 = f7;
        fld.funct3 = f3;
        fld.rs1    = ins_i[19:15];
        fld.rs2    = ins_i[24:20];
        fld.rd     = ins_i[11:7];
      end
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM, OPC_SYSTEM: begin
        fld.fmt    = FMT_I;
        fld.funct3 = f3;
        fld.rs1    = ins_i[19:15];
        fld.rd     = ins_i[11:7];
        imm        = XLEN'($signed(ins_i[31:20]));
        legal      = 1'b1;
        if (op == OPC_OP_IMM && (f3 == 3'b001 || f3 == 3'b101)) begin
          // Shifts carry funct7 and a zero-extended shamt instead of imm12.
          fld.funct7 = f7;
          imm        = XLEN'(ins_i[24:20]);
          legal      = (f7 == F7_ZERO) || ((f7 == F7_ALT) && (f3 == 3'b101));
        end else if (op == OPC_LOAD) begin
          legal = !((f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111));
        end else if (op == OPC_JALR) begin
          legal = (f3 == 3'b000);
        end
      end
      OPC_STORE: begin
        legal      = (f3 < 3'b011);
        fld.fmt    = FMT_S;
        fld.funct3 = f3;
        fld.rs1    = ins_i[19:15];
        fld.rs2    = ins_i[24:20];
        imm        = XLEN'($signed({ins_i[31:25], ins_i[11:7]}));
      end
      OPC_BRANCH: begin
        legal      = !((f3 == 3'b010) || (f3 == 3'b011));
        fld.fmt    = FMT_B;
        fld.funct3 = f3;
        fld.rs1    = ins_i[19:15];
        fld.rs2    = ins_i[24:20];
        imm        = XLEN'($signed({ins_i[31], ins_i[7], ins_i[30:25], ins_i[11:8], 1'b0}));
      end
      OPC_LUI, OPC_AUIPC: begin
        legal   = 1'b1;
        fld.fmt = FMT_U;
        fld.rd  = ins_i[11:7];
        imm     = XLEN'($signed({ins_i[31:12], 12'b0}));
      end
      OPC_JAL: begin
        legal   = 1'b1;
        fld.fmt = FMT_J;
        fld.rd  = ins_i[11:7];
        imm     = XLEN'($signed({ins_i[31], ins_i[19:12], ins_i[20], ins_i[30:21], 1'b0}));
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      fld         = '0;
      fld.op      = op;
      fld.fmt     = FMT_ILL;
      fld.illegal = 1'b1;
      imm         = '0;
    end
  end

  assign fld_o = fld;
  assign imm_o = imm;

endmodule

// File: rtl/ins_dec_stage.sv
// Registered decode stage: decode on entry, 2-entry skid buffer toward execute, illegal counter.
module ins_dec_stage
  import ins_dec_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_ins,
  input  logic [XLEN-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_op,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [CNT_W-1:0] ill_cnt
);

  dec_fields_t     dec_fld;
  logic [XLEN-1:0] dec_imm;

  logic            m_valid_q, m_valid_d, s_valid_q, s_valid_d;
  dec_fields_t     m_fld_q, m_fld_d, s_fld_q, s_fld_d;
  logic [XLEN-1:0] m_pc_q, m_pc_d, s_pc_q, s_pc_d;
  logic [XLEN-1:0] m_imm_q, m_imm_d, s_imm_q, s_imm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            accept, drain;

  ins_dec_comb #(.XLEN(XLEN)) u_dec (
    .ins_i (in_ins),
    .fld_o (dec_fld),
    .imm_o (dec_imm)
  );

  assign accept = in_valid && !s_valid_q;
  assign drain  = m_valid_q && out_ready;

  // Skid-buffer steering: S refills M first, new entries land in M when it frees, else in S.
  always_comb begin
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;
    m_fld_d   = m_fld_q;
    m_pc_d    = m_pc_q;
    m_imm_d   = m_imm_q;
    s_fld_d   = s_fld_q;
    s_pc_d    = s_pc_q;
    s_imm_d   = s_imm_q;
    cnt_d     = cnt_q;
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (s_valid_q) begin
      if (drain) begin
        m_fld_d   = s_fld_q;
        m_pc_d    = s_pc_q;
        m_imm_d   = s_imm_q;
        s_valid_d = 1'b0;
      end
    end else if (!m_valid_q || drain) begin
      m_valid_d = accept;
      if (accept) begin
        m_fld_d = dec_fld;
        m_pc_d  = in_pc;
        m_imm_d = dec_imm;
      end
    end else if (accept) begin
      s_valid_d = 1'b1;
      s_fld_d   = dec_fld;
      s_pc_d    = in_pc;
      s_imm_d   = dec_imm;
    end
    // Counts every illegal entry execute actually takes, saturating.
    if (drain && m_fld_q.illegal && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      s_valid_q <= 1'b0;
      m_fld_q   <= '0;
      m_pc_q    <= '0;
      m_imm_q   <= '0;
      s_fld_q   <= '0;
      s_pc_q    <= '0;
      s_imm_q   <= '0;
      cnt_q     <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      s_valid_q <= s_valid_d;
      m_fld_q   <= m_fld_d;
      m_pc_q    <= m_pc_d;
      m_imm_q   <= m_imm_d;
      s_fld_q   <= s_fld_d;
      s_pc_q    <= s_pc_d;
      s_imm_q   <= s_imm_d;
      cnt_q     <= cnt_d;
    end
  end

  assign in_ready    = !s_valid_q;
  assign out_valid   = m_valid_q;
  assign out_pc      = m_pc_q;
  assign out_op      = m_fld_q.op;
  assign out_funct3  = m_fld_q.funct3;
  assign out_funct7  = m_fld_q.funct7;
  assign out_rs1     = m_fld_q.rs1;
  assign out_rs2     = m_fld_q.rs2;
  assign out_rd      = m_fld_q.rd;
  assign out_imm     = m_imm_q;
  assign out_fmt     = m_fld_q.fmt;
  assign out_illegal = m_fld_q.illegal;
  assign ill_cnt     = cnt_q;

endmodule

// File: tb/tb_ins_dec_stage.sv
// Scoreboard bench for ins_dec_stage: reference decoder feeds a queue, monitor checks deliveries.
module tb_ins_dec_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0]      in_ins;
  logic [XLEN-1:0]  in_pc, out_pc, out_imm;
  logic [6:0]       out_op, out_funct7;
  logic [2:0]       out_funct3, out_fmt;
  logic [4:0]       out_rs1, out_rs2, out_rd;
  logic [CNT_W-1:0] ill_cnt;

  always #5 clk = ~clk;

  ins_dec_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_ins(in_ins), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_op(out_op),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_rd(out_rd), .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .ill_cnt(ill_cnt)
  );

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      op;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [4:0]      rs1, rs2, rd;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            ill;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  int unsigned ill_model = 0;
  bit          rand_rdy = 0;

  function automatic longint sx12(input logic [11:0] x);
    return longint'(x) - (x[11] ? 64'sd4096 : 64'sd0);
  endfunction

  // Reference decoder: format table plus arithmetic immediate assembly.
  function automatic exp_t model(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    exp_t e; longint v; bit ok;
    logic [2:0] f3; logic [6:0] f7;
    f3 = ins[14:12]; f7 = ins[31:25];
    e = '0; e.pc = pc; e.op = ins[6:0]; v = 0; ok = 1;
    case (ins[6:0])
      7'h33: begin
        e.fmt = 0; ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
        e.f7 = f7; e.f3 = f3; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
      end
      7'h13, 7'h03, 7'h67, 7'h0F, 7'h73: begin
        e.fmt = 1; e.f3 = f3; e.rs1 = ins[19:15]; e.rd = ins[11:7]; v = sx12(ins[31:20]);
        if (ins[6:0] == 7'h13 && (f3 == 1 || f3 == 5)) begin
          e.f7 = f7; v = longint'(ins[24:20]);
          ok = (f7 == 0) || (f7 == 7'h20 && f3 == 5);
        end
        if (ins[6:0] == 7'h03) ok = !(f3 == 3 || f3 == 6 || f3 == 7);
        if (ins[6:0] == 7'h67) ok = (f3 == 0);
      end
      7'h23: begin
        e.fmt = 2; ok = (f3 < 3); e.f3 = f3; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        v = sx12({ins[31:25], ins[11:7]});
      end
      7'h63: begin
        e.fmt = 3; ok = !(f3 == 2 || f3 == 3); e.f3 = f3; e.rs1 = ins[19:15]; e.rs2 = ins[24:20];
        v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
            - (ins[31] ? 64'sd4096 : 64'sd0);
      end
      7'h37, 7'h17: begin
        e.fmt = 4; e.rd = ins[11:7];
        v = longint'(ins[31:12]) * 4096 - (ins[31] ? (longint'(1) << 32) : 64'sd0);
      end
      7'h6F: begin
        e.fmt = 5; e.rd = ins[11:7];
        v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
            - (ins[31] ? (longint'(1) << 20) : 64'sd0);
      end
      default: ok = 0;
    endcase
    e.imm = v[XLEN-1:0];
    if (!ok) begin
      e = '0; e.pc = pc; e.op = ins[6:0]; e.fmt = 7; e.ill = 1;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Offer one instruction, holding it until accepted; expected result queued at acceptance.
  task automatic send(input logic [31:0] ins, input logic [XLEN-1:0] pc);
    bit hs;
    in_valid = 1'b1; in_ins = ins; in_pc = pc;
    for (int i = 0; i < 60; i++) begin
      hs = in_ready;
      @(posedge clk); #1;
      if (hs) begin
        sb_q.push_back(model(ins, pc));
        return;
      end
    end
    checks++; failures++;
    $display("FAIL send_timeout ins=%h never accepted", ins);
  endtask

  task automatic send_chk(input logic [31:0] ins, input logic [XLEN-1:0] exp_imm,
                          input logic [2:0] exp_fmt);
    send(ins, XLEN'($urandom));
    @(negedge clk);
    chk("latency_valid", out_valid, 1);
    chk("dir_imm", out_imm, exp_imm);
    chk("dir_fmt", out_fmt, exp_fmt);
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  function automatic logic [31:0] gen_ins();
    logic [6:0] opcs [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                              7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 7) != 0) begin
      r[6:0] = opcs[$urandom_range(0, 10)];
      if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    end
    return r;
  endfunction

  // Monitor: every output handshake pops one expected entry.
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output pc=%h op=%h", out_pc, out_op);
        end else begin
          e = sb_q.pop_front();
          a.pc = out_pc; a.op = out_op; a.f3 = out_funct3; a.f7 = out_funct7;
          a.rs1 = out_rs1; a.rs2 = out_rs2; a.rd = out_rd; a.imm = out_imm;
          a.fmt = out_fmt; a.ill = out_illegal;
          checks++;
          if (a !== e) begin
            failures++;
            $display("FAIL entry actual=%h required=%h", a, e);
          end
          chk("ill_cnt", ill_cnt, ill_model);
          if (e.ill && ill_model < 65535) ill_model++;
        end
      end
    end
  end

  // Random backpressure on the output side.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_ins = '0; in_pc = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_ill_cnt", ill_cnt, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_rd", out_rd, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    send_chk(32'h003100B3, '0, 3'd0);
    chk("add_rs1", out_rs1, 2); chk("add_rs2", out_rs2, 3); chk("add_rd", out_rd, 1);
    send_chk(32'hAAA14093, XLEN'(64'hFFFFFFFFFFFFFAAA), 3'd1);
    chk("i_rs2", out_rs2, 0);
    send_chk(32'hAA20A523, XLEN'(64'hFFFFFFFFFFFFFAAA), 3'd2);
    chk("s_rd", out_rd, 0);
    send_chk(32'hD420FA63, XLEN'(64'hFFFFFFFFFFFFF554), 3'd3);
    chk("b_funct3", out_funct3, 7);
    send_chk(32'hD54550EF, XLEN'(64'hFFFFFFFFFFF55554), 3'd5);
    chk("j_rd", out_rd, 1);
    send_chk(32'hAAAAA0B7, XLEN'(64'hFFFFFFFFAAAAA000), 3'd4);
    chk("u_rd", out_rd, 1); chk("u_f3", out_funct3, 0); chk("u_rs1", out_rs1, 0);
    idle();

    // Backpressure: two accepted, third held until release.
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h00A00093, XLEN'('h200));
    send(32'h40208133, XLEN'('h204));
    chk("bp_in_ready", in_ready, 0);
    in_ins = 32'h00C00193; in_pc = XLEN'('h208);
    repeat (2) begin @(posedge clk); #1; end
    chk("bp_held_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    out_ready = 1'b1;
    send(32'h00C00193, XLEN'('h208));
    idle();
    repeat (4) begin @(posedge clk); #1; end

    // Illegal entries bump the counter.
    chk("ill_before", ill_cnt, 0);
    send(32'h00000000, XLEN'('h300));
    send(32'h0000A063, XLEN'('h304));
    idle();
    repeat (3) begin @(posedge clk); #1; end
    chk("ill_after", ill_cnt, 2);

    // Flush with two buffered and one offered.
    out_ready = 1'b0;
    send(32'h00100213, XLEN'('h400));
    send(32'h00200293, XLEN'('h404));
    in_valid = 1'b1; in_ins = 32'h00300313; in_pc = XLEN'('h408); flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; idle();
    sb_q.delete();
    chk("flush_out_valid", out_valid, 0);
    chk("flush_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (5) begin @(posedge clk); #1; end
    chk("flush_ill_cnt", ill_cnt, 2);

    // Randomized traffic with random backpressure.
    rand_rdy = 1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        idle();
        @(posedge clk); #1;
      end else begin
        send(gen_ins(), XLEN'({$urandom, $urandom}));
      end
    end
    idle();
    rand_rdy = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", sb_q.size(), 0);
    repeat (2) begin @(posedge clk); #1; end
    chk("final_ill_cnt", ill_cnt, ill_model);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
